// File: rtl/tpg_multi.sv
// Multi-pattern video test pattern generator with programmable sync/active timing.
// All configuration is shadowed at frame start, so inputs may change freely mid-frame.
module tpg_multi #(
  parameter int PW      = 8,
  parameter int H_BITS  = 12,
  parameter int V_BITS  = 12,
  parameter int FC_BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [3*PW-1:0]    solid_rgb,
  input  logic [H_BITS-1:0]  bar_w,
  input  logic [3:0]         ck_shift,
  input  logic [H_BITS-1:0]  tHS_START,
  input  logic [H_BITS-1:0]  tHS_END,
  input  logic [H_BITS-1:0]  tHACT_START,
  input  logic [H_BITS-1:0]  tHACT_END,
  input  logic [H_BITS-1:0]  tH_END,
  input  logic [V_BITS-1:0]  tVS_START,
  input  logic [V_BITS-1:0]  tVS_END,
  input  logic [V_BITS-1:0]  tVACT_START,
  input  logic [V_BITS-1:0]  tVACT_END,
  input  logic [V_BITS-1:0]  tV_END,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               sof,
  output logic               eol,
  output logic [3*PW-1:0]    rgb,
  output logic [FC_BITS-1:0] frame_cnt,
  output logic               busy
);

  localparam logic [H_BITS-1:0]  H_ONE = {{(H_BITS-1){1'b0}}, 1'b1};
  localparam logic [V_BITS-1:0]  V_ONE = {{(V_BITS-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]      P_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [FC_BITS-1:0] F_ONE = {{(FC_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_reg;

  logic [H_BITS-1:0] x_reg, bar_pc_reg;
  logic [V_BITS-1:0] y_reg;
  logic [PW-1:0]     cnt_reg;
  logic [2:0]        bar_reg;

  logic [H_BITS-1:0] hs_start_reg, hs_end_reg, hact_start_reg, hact_end_reg, h_end_reg, bar_w_reg;
  logic [V_BITS-1:0] vs_start_reg, vs_end_reg, vact_start_reg, vact_end_reg, v_end_reg;
  logic [2:0]        mode_reg;
  logic [3*PW-1:0]   solid_reg;
  logic [3:0]        ck_shift_reg;

  logic [H_BITS-1:0] h_last, hact_last, xa, xs, bar_len, bar_pc_cur, bar_pc_inc, bar_pc_next;
  logic [V_BITS-1:0] v_last, ya, ys;
  logic              h_wrap, v_wrap, frame_end, latch_cfg;
  logic              hs_next, vs_next, de_next, sof_next, eol_next, ck_dark;
  logic [2:0]        bar_cur, bar_next, bar_mask;
  logic [3*PW-1:0]   legacy_rgb, bar_rgb, pix, rgb_next;

  // A zero end value makes the "-1" wrap to all-ones, giving the full counter range.
  assign h_last    = h_end_reg - H_ONE;
  assign v_last    = v_end_reg - V_ONE;
  assign hact_last = hact_end_reg - H_ONE;
  assign h_wrap    = (x_reg == h_last);
  assign v_wrap    = (y_reg == v_last);
  assign frame_end = h_wrap && v_wrap;
  assign latch_cfg = en && ((state_reg == IDLE) || frame_end);

  assign xa = x_reg - hact_start_reg;
  assign ya = y_reg - vact_start_reg;
  assign xs = xa >> ck_shift_reg;
  assign ys = ya >> ck_shift_reg;

  assign hs_next  = (x_reg >= hs_start_reg) && (x_reg < hs_end_reg);
  assign vs_next  = (y_reg >= vs_start_reg) && (y_reg < vs_end_reg);
  assign de_next  = (x_reg >= hact_start_reg) && (x_reg < hact_end_reg) &&
                    (y_reg >= vact_start_reg) && (y_reg < vact_end_reg);
  assign sof_next = de_next && (xa == '0) && (ya == '0);
  assign eol_next = de_next && (x_reg == hact_last);
  assign ck_dark  = xs[0] ^ ys[0];

  // Bar state restarts on the first active pixel of each line.
  assign bar_len     = (bar_w_reg == '0) ? H_ONE : bar_w_reg;
  assign bar_cur     = (xa == '0) ? 3'd0 : bar_reg;
  assign bar_pc_cur  = (xa == '0) ? '0 : bar_pc_reg;
  assign bar_pc_inc  = bar_pc_cur + H_ONE;
  assign bar_pc_next = (bar_pc_inc >= bar_len) ? '0 : bar_pc_inc;
  assign bar_next    = (bar_pc_inc < bar_len || bar_cur == 3'd7) ? bar_cur : bar_cur + 3'd1;

  always_comb begin
    bar_mask = 3'b000;
    case (bar_cur)
      3'd0: bar_mask = 3'b111;
      3'd1: bar_mask = 3'b110;
      3'd2: bar_mask = 3'b011;
      3'd3: bar_mask = 3'b010;
      3'd4: bar_mask = 3'b101;
      3'd5: bar_mask = 3'b100;
      3'd6: bar_mask = 3'b001;
      default: bar_mask = 3'b000;
    endcase
  end

  // Component gi = 0 is B (LSBs), 2 is R.
  for (genvar gi = 0; gi < 3; gi++) begin : g_comp
    assign legacy_rgb[gi*PW +: PW] = cnt_reg;
    assign bar_rgb[gi*PW +: PW]    = {PW{bar_mask[gi]}};
  end

  always_comb begin
    pix = solid_reg;
    case (mode_reg)
      3'd0: pix = legacy_rgb;
      3'd1: pix = {xa[PW-1:0], ya[PW-1:0], frame_cnt[PW-1:0]};
      3'd2: pix = bar_rgb;
      3'd3: pix = ck_dark ? solid_reg : '1;
      default: pix = solid_reg;
    endcase
    rgb_next = de_next ? pix : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_start_reg <= '0; hs_end_reg <= '0; hact_start_reg <= '0; hact_end_reg <= '0;
      h_end_reg    <= '0; vs_start_reg <= '0; vs_end_reg <= '0; vact_start_reg <= '0;
      vact_end_reg <= '0; v_end_reg <= '0; mode_reg <= '0; solid_reg <= '0;
      bar_w_reg    <= '0; ck_shift_reg <= '0;
    end else if (latch_cfg) begin
      hs_start_reg <= tHS_START;   hs_end_reg <= tHS_END;
      hact_start_reg <= tHACT_START; hact_end_reg <= tHACT_END; h_end_reg <= tH_END;
      vs_start_reg <= tVS_START;   vs_end_reg <= tVS_END;
      vact_start_reg <= tVACT_START; vact_end_reg <= tVACT_END; v_end_reg <= tV_END;
      mode_reg <= mode; solid_reg <= solid_rgb; bar_w_reg <= bar_w; ck_shift_reg <= ck_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg <= '0; y_reg <= '0; cnt_reg <= '0; bar_reg <= '0; bar_pc_reg <= '0;
      hs <= 1'b0; vs <= 1'b0; de <= 1'b0; sof <= 1'b0; eol <= 1'b0;
      rgb <= '0; frame_cnt <= '0; busy <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          hs <= 1'b0; vs <= 1'b0; de <= 1'b0; sof <= 1'b0; eol <= 1'b0;
          rgb <= '0; busy <= 1'b0;
          if (en) begin
            state_reg <= RUN;
            x_reg <= '0;
            y_reg <= '0;
          end
        end
        default: begin
          hs <= hs_next; vs <= vs_next; de <= de_next; sof <= sof_next; eol <= eol_next;
          rgb <= rgb_next; busy <= 1'b1;
          if (de_next) begin
            cnt_reg    <= cnt_reg + P_ONE;
            bar_reg    <= bar_next;
            bar_pc_reg <= bar_pc_next;
          end
          if (h_wrap) begin
            x_reg <= '0;
            if (v_wrap) begin
              y_reg     <= '0;
              frame_cnt <= frame_cnt + F_ONE;
              if (!en) state_reg <= IDLE;
            end else begin
              y_reg <= y_reg + V_ONE;
            end
          end else begin
            x_reg <= x_reg + H_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpg_multi.sv
// Directed bench for tpg_multi: a 20x8 raster with a 10x4 active window,
// walking through every pattern, shadowing, en stop/restart and mid-line reset.
module tb_tpg_multi;
  localparam int PW = 8, H_BITS = 12, V_BITS = 12, FC_BITS = 16;
  localparam int H_END = 20, FRAME = 160;

  logic clk = 1'b0;
  logic rst, en;
  logic [2:0] mode;
  logic [3*PW-1:0] solid_rgb;
  logic [H_BITS-1:0] bar_w;
  logic [3:0] ck_shift;
  logic [H_BITS-1:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [V_BITS-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
  logic hs, vs, de, sof, eol, busy;
  logic [3*PW-1:0] rgb;
  logic [FC_BITS-1:0] frame_cnt;

  int n_cmp = 0, n_bad = 0;
  int pos, fc_exp;
  logic [7:0] leg;
  int c_hs, c_vs, c_de, c_sof, c_eol;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  tpg_multi #(.PW(PW), .H_BITS(H_BITS), .V_BITS(V_BITS), .FC_BITS(FC_BITS)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb), .bar_w(bar_w),
    .ck_shift(ck_shift), .tHS_START(tHS_START), .tHS_END(tHS_END),
    .tHACT_START(tHACT_START), .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
    .tVACT_END(tVACT_END), .tV_END(tV_END), .hs(hs), .vs(vs), .de(de), .sof(sof),
    .eol(eol), .rgb(rgb), .frame_cnt(frame_cnt), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_hs"}, 32'(hs), 0);
    check_val({tag, "_vs"}, 32'(vs), 0);
    check_val({tag, "_de"}, 32'(de), 0);
    check_val({tag, "_sof"}, 32'(sof), 0);
    check_val({tag, "_eol"}, 32'(eol), 0);
    check_val({tag, "_rgb"}, 32'(rgb), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Each sample after an edge shows the outputs for raster position pos.
  task automatic run_span(input int n, input int md);
    int x, y, xa, ya;
    logic de_e;
    logic [23:0] exp_rgb;
    for (int i = 0; i < n; i++) begin
      step();
      x = pos % H_END;
      y = pos / H_END;
      xa = x - 6;
      ya = y - 2;
      de_e = (x >= 6) && (x < 16) && (y >= 2) && (y < 6);
      exp_rgb = 24'h0;
      if (de_e) begin
        case (md)
          0: exp_rgb = {leg, leg, leg};
          1: exp_rgb = {8'(xa), 8'(ya), 8'(fc_exp)};
          2: exp_rgb = bar_tab[(xa > 7) ? 7 : xa];
          3: exp_rgb = ((((xa >> 1) ^ (ya >> 1)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
          default: exp_rgb = 24'h112233;
        endcase
      end
      check_val($sformatf("hs@%0d", pos), 32'(hs), 32'((x >= 2) && (x < 4)));
      check_val($sformatf("vs@%0d", pos), 32'(vs), 32'(y == 1));
      check_val($sformatf("de@%0d", pos), 32'(de), 32'(de_e));
      check_val($sformatf("sof@%0d", pos), 32'(sof), 32'(x == 6 && y == 2));
      check_val($sformatf("eol@%0d", pos), 32'(eol), 32'(de_e && x == 15));
      check_val($sformatf("rgb@%0d m%0d", pos, md), 32'(rgb), 32'(exp_rgb));
      check_val($sformatf("busy@%0d", pos), 32'(busy), 1);
      check_val($sformatf("fcnt@%0d", pos), 32'(frame_cnt), 32'(fc_exp + ((pos == FRAME - 1) ? 1 : 0)));
      c_hs += int'(hs); c_vs += int'(vs); c_de += int'(de); c_sof += int'(sof); c_eol += int'(eol);
      if (de_e && md == 0) leg++;
      pos++;
      if (pos == FRAME) begin
        pos = 0;
        fc_exp++;
      end
    end
    $display("span mode=%0d cycles=%0d next_pos=%0d frames=%0d", md, n, pos, fc_exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd4; solid_rgb = 24'h112233; bar_w = 12'd1; ck_shift = 4'd0;
    tHS_START = 12'd2; tHS_END = 12'd4; tHACT_START = 12'd6; tHACT_END = 12'd16; tH_END = 12'd20;
    tVS_START = 12'd1; tVS_END = 12'd2; tVACT_START = 12'd2; tVACT_END = 12'd6; tV_END = 12'd8;
    step(); step(); step();
    check_idle("reset");
    check_val("reset_fcnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    step();
    check_idle("idle_no_en");
    en = 1'b1;
    step();
    check_idle("latch_cycle");

    // Solid frame: timing and aggregate counts
    pos = 0; fc_exp = 0; leg = 8'h00;
    c_hs = 0; c_vs = 0; c_de = 0; c_sof = 0; c_eol = 0;
    run_span(FRAME, 4);
    check_val("frame_hs_cnt", 32'(c_hs), 16);
    check_val("frame_vs_cnt", 32'(c_vs), 20);
    check_val("frame_de_cnt", 32'(c_de), 40);
    check_val("frame_sof_cnt", 32'(c_sof), 1);
    check_val("frame_eol_cnt", 32'(c_eol), 4);

    // Legacy counter from a fresh reset, two frames
    rst = 1'b1; mode = 3'd0;
    step();
    check_idle("rst_legacy");
    check_val("rst_legacy_fcnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    step();
    pos = 0; fc_exp = 0; leg = 8'h00;
    run_span(FRAME, 0);
    check_val("legacy_after_f0", 32'(leg), 32'h28);
    mode = 3'd2; tH_END = 12'd30;
    run_span(80, 0);
    tH_END = 12'd20;
    run_span(80, 0);

    // Bars, then checker and ramp, each set mid-way through the preceding frame
    run_span(80, 2);
    mode = 3'd3; ck_shift = 4'd1; solid_rgb = 24'h000000;
    run_span(80, 2);
    run_span(80, 3);
    mode = 3'd1;
    run_span(80, 3);
    run_span(80, 1);
    en = 1'b0; mode = 3'd4; solid_rgb = 24'h112233;
    run_span(80, 1);

    // Stopped: outputs stay low, frame count holds
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle($sformatf("stopped%0d", i));
      check_val($sformatf("stopped%0d_fcnt", i), 32'(frame_cnt), 5);
    end

    en = 1'b1;
    step();
    check_idle("restart_latch");
    pos = 0;
    run_span(45, 4);

    // Mid-line reset
    rst = 1'b1;
    step();
    check_idle("midline_rst");
    check_val("midline_rst_fcnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    step();
    pos = 0; fc_exp = 0;
    run_span(25, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tpg_multi.md
Name: tpg_multi

Overview:
- Parametrised multi-pattern video test pattern generator; successor to the single-pattern counter TPG.
- Generates programmable H/V sync, data-enable, start-of-frame and end-of-line timing.
- Drives one RGB pixel per clock from five selectable patterns.
- Sits at the head of the video pipeline as a stand-in source for scaler, encoder and output benches; frame-atomic start/stop via en.

Parameters:
- PW, 8, bits per colour component
- H_BITS, 12, width of horizontal counter and timing inputs
- V_BITS, 12, width of vertical counter and timing inputs
- FC_BITS, 16, width of frame counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  run request, sampled at frame boundaries
- mode  in  3  pattern select: 0 legacy counter, 1 ramp, 2 colour bars, 3 checkerboard, 4 solid; 5-7 act as 4
- solid_rgb  in  3*PW  {R,G,B} for solid mode and checker "dark" squares
- bar_w  in  H_BITS  active pixels per colour bar
- ck_shift  in  4  checker square size = 2^ck_shift
- tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END  in  H_BITS each  horizontal timing
- tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END  in  V_BITS each  vertical timing
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  data enable (active pixel)
- sof  out  1  first active pixel of frame
- eol  out  1  last active pixel of a line
- rgb  out  3*PW  {R,G,B}; zero whenever de=0
- frame_cnt  out  FC_BITS  completed frames since reset, wraps
- busy  out  1  high in RUN

Behaviour:
- Reset: state IDLE; x=y=0; hs=vs=de=sof=eol=busy=0; rgb=0; frame_cnt=0; legacy cnt=0.
- Config shadowing: all config inputs (timing, mode, solid_rgb, bar_w, ck_shift) are latched into shadow registers on IDLE->RUN and at every frame wrap. Mid-frame input changes have no effect.
- FSM IDLE: outputs 0. If en=1, latch config; next cycle is RUN at x=0, y=0.
- FSM RUN: x increments every cycle. At x==tH_END-1, x->0 and y increments. At y==tV_END-1 with the line wrapping, y->0, frame_cnt++ and en is sampled: en=1 relatches config and stays RUN; en=0 goes to IDLE. en low mid-frame always completes the frame.
- tH_END=0 / tV_END=0: counter runs its full 2^BITS range.
- Range decode from the current (x,y):
  - hs = tHS_START<=x<tHS_END
  - vs = tVS_START<=y<tVS_END
  - de = tHACT_START<=x<tHACT_END and tVACT_START<=y<tVACT_END
  - Any START>=END: that signal is never asserted.
- Latency: every output is registered and reflects counter position (x,y) one cycle later. busy is also registered.
- Active coordinates: xa = x-tHACT_START, ya = y-tVACT_START (truncated to counter width).
- sof = de & xa==0 & ya==0. eol = de & x==tHACT_END-1.
- Mode 0 (legacy): rgb = {cnt,cnt,cnt}; cnt is a PW-bit counter that increments after each de pixel, wraps, and is not cleared per frame. The first de pixel after reset shows 0.
- Mode 1 (ramp): R = xa[PW-1:0], G = ya[PW-1:0], B = frame_cnt[PW-1:0].
- Mode 2 (colour bars):
  - Bar index b starts at 0 on each line's first de pixel and increments after every bar_w de pixels, saturating at 7. bar_w=0 is treated as 1.
  - {R,G,B} on/off per b: 0=111 white, 1=110 yellow, 2=011 cyan, 3=010 green, 4=101 magenta, 5=100 red, 6=001 blue, 7=000 black.
  - "on" = all-ones, "off" = 0.
- Mode 3 (checker): square parity p = xa[ck_shift] ^ ya[ck_shift]; p=0 gives all-ones, p=1 gives solid_rgb. A ck_shift beyond the counter width uses bit 0 of 0, so p=0.
- Mode 4 (solid): rgb = solid_rgb.
- rst asserted mid-frame: next cycle is full reset state and outputs 0; no partial frame resumes.

Test Plan:
- Timing: tH_END=20, tHS 2..4, tHACT 6..16, tV_END=8, tVS 1..2, tVACT 2..6, mode 4, solid 0x112233, en=1.
  - Per frame: 160 cycles; hs high 2 cycles per line; vs high 20 cycles; de 10 pixels x 4 lines.
  - sof once at first de; eol on each 10th de pixel; rgb=0x112233 during de, else 0.
  - Each output lags the position by 1 cycle.
- Same timing, mode 0: rgb walks 0x000000..0x272727 over 40 de pixels in frame 0. Frame 1 continues at 0x282828.
- Mode 2, bar_w=1: each line's rgb sequence is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, 000000, 000000 (saturation at 7).
- Mode 3, ck_shift=1, solid 0: line ya=0 shows FFFFFF,FFFFFF,0,0 repeating; line ya=2 is inverted.
- en dropped at mid-frame 0: frame completes, frame_cnt=1, busy falls. IDLE outputs stay 0. Re-raising en restarts at x=y=0 with the new mode.
- Change tH_END and mode mid-frame: no effect until the next frame. Pulse rst mid-line: all outputs 0 the following cycle, frame_cnt=0.
